decompress_bit: RTL and testbench



---
 rtl/cpri_comp_pkg.sv | 29 ++
 rtl/bfp_expand_lane.sv | 40 ++++
 rtl/decompress_bit.sv | 179 +++++++++++++++++
 tb/tb_decompress_bit.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpri_comp_pkg.sv
// Shared definitions for the CPRI PUSCH block-floating-point compress/decompress path.
// Holds the exponent and sample width constants plus the sideband record that
// travels alongside each I/Q sample.
package cpri_comp_pkg;

    localparam int unsigned SHIFT_W   = 4;
    localparam int unsigned SHIFT_MAX = 9;
    localparam int unsigned IQ_W      = 16;

    typedef struct packed {
        logic [6:0] slot;
        logic [3:0] symb;
        logic [8:0] prb;
        logic [3:0] ch_type;
        logic [7:0] info;
    } sideband_t;

    // Everything that rides the control pipeline next to the data path.
    typedef struct packed {
        logic      sel;
        logic      sop;
        logic      eop;
        logic      vld;
        logic      len_err;
        logic      shift_err;
        sideband_t sb;
    } ctrl_t;

endpackage

// File: rtl/bfp_expand_lane.sv
// bfp_expand_lane: re-expands one Num-bit two's complement mantissa to IQ_W bits.
// The mantissa is left-justified into IQ_W bits and arithmetically shifted right
// by the block exponent; the result is registered and forced to zero on invalid
// cycles.
//   clk, rst  clock and synchronous active-high reset
//   i_vld     sample valid
//   i_mant    Num-bit signed mantissa
//   i_shift   block exponent (0..15)
//   o_y       registered IQ_W-bit expanded sample
module bfp_expand_lane
    import cpri_comp_pkg::*;
#(
    parameter int unsigned Num = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_vld,
    input  logic [Num-1:0]     i_mant,
    input  logic [SHIFT_W-1:0] i_shift,
    output logic [IQ_W-1:0]    o_y
);

    logic signed [IQ_W-1:0] w_ext;
    logic        [IQ_W-1:0] r_y;

    assign w_ext = {i_mant, {(IQ_W - Num){1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y <= '0;
        end else if (i_vld) begin
            r_y <= w_ext >>> i_shift;
        end else begin
            r_y <= '0;
        end
    end

    assign o_y = r_y;

endmodule

// File: rtl/decompress_bit.sv
// decompress_bit: block-floating-point I/Q decompressor for the CPRI PUSCH path.
// Expands Num-bit I/Q mantissas to 16 bits each, checks PRB framing and exponent
// consistency, and delays controls/sideband so everything leaves 3 cycles later.
//   clk, rst                         clock and synchronous active-high reset
//   i_sel/i_sop/i_eop/i_vld          lane select, PRB start/end, sample valid
//   i_din                            {I mantissa, Q mantissa}
//   i_shift                          block exponent, latched on sop
//   i_slot_idx..i_info               sideband, delayed unchanged
//   o_sel/o_sop/o_eop/o_vld          delayed controls
//   o_dout                           {I[15:0], Q[15:0]}, zero on invalid cycles
//   o_slot_idx..o_info               delayed sideband
//   o_len_err / o_shift_err          per-sample error pulses, aligned to o_dout
module decompress_bit
    import cpri_comp_pkg::*;
#(
    parameter int unsigned Num     = 7,
    parameter int unsigned PRB_LEN = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_sel,
    input  logic               i_sop,
    input  logic               i_eop,
    input  logic               i_vld,
    input  logic [2*Num-1:0]   i_din,
    input  logic [SHIFT_W-1:0] i_shift,
    input  logic [6:0]         i_slot_idx,
    input  logic [3:0]         i_symb_idx,
    input  logic [8:0]         i_prb_idx,
    input  logic [3:0]         i_ch_type,
    input  logic [7:0]         i_info,
    output logic               o_sel,
    output logic               o_sop,
    output logic               o_eop,
    output logic               o_vld,
    output logic [31:0]        o_dout,
    output logic [6:0]         o_slot_idx,
    output logic [3:0]         o_symb_idx,
    output logic [8:0]         o_prb_idx,
    output logic [3:0]         o_type,
    output logic [7:0]         o_info,
    output logic               o_len_err,
    output logic               o_shift_err
);

    localparam int unsigned        CNT_W       = $clog2(PRB_LEN + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
    localparam logic [CNT_W-1:0]   CNT_PRB     = CNT_W'(PRB_LEN);
    localparam logic [SHIFT_W-1:0] SHIFT_LIMIT = SHIFT_W'(SHIFT_MAX);

    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [CNT_W-1:0]   w_cnt_d;
    logic [SHIFT_W-1:0] r_shift_q;
    logic [SHIFT_W-1:0] w_shift_use;
    logic               w_len_err;
    logic               w_shift_err;
    ctrl_t              w_s1_ctrl;

    ctrl_t              r_s1_ctrl;
    logic [2*Num-1:0]   r_s1_din;
    logic [SHIFT_W-1:0] r_s1_shift;
    ctrl_t              r_s2_ctrl;
    ctrl_t              r_s3_ctrl;
    logic [31:0]        r_dout;
    logic [IQ_W-1:0]    w_y_i;
    logic [IQ_W-1:0]    w_y_q;

    // Framing and exponent checks; only valid samples touch cnt and shift_q.
    always_comb begin
        w_cnt_d     = r_cnt;
        w_len_err   = 1'b0;
        w_shift_err = 1'b0;
        // A sop sample uses its own exponent; everything else (including orphans)
        // uses the latched one.
        w_shift_use = (i_vld && i_sop) ? i_shift : r_shift_q;
        if (i_sop) begin
            w_cnt_inc = CNT_W'(1);
        end else if (r_cnt == CNT_MAX) begin
            w_cnt_inc = r_cnt;
        end else begin
            w_cnt_inc = r_cnt + 1'b1;
        end

        if (i_vld) begin
            w_cnt_d = i_eop ? '0 : w_cnt_inc;
            if (i_sop && (r_cnt != '0)) begin
                w_len_err = 1'b1;
            end
            if (!i_sop && (r_cnt == '0)) begin
                w_len_err = 1'b1;
            end
            if (i_eop && (w_cnt_inc != CNT_PRB)) begin
                w_len_err = 1'b1;
            end
            // Out-of-range exponent is flagged on every sample that uses it.
            if (w_shift_use > SHIFT_LIMIT) begin
                w_shift_err = 1'b1;
            end
            if (!i_sop && (i_shift != r_shift_q)) begin
                w_shift_err = 1'b1;
            end
        end
    end

    always_comb begin
        w_s1_ctrl.sel        = i_sel;
        w_s1_ctrl.sop        = i_sop;
        w_s1_ctrl.eop        = i_eop;
        w_s1_ctrl.vld        = i_vld;
        w_s1_ctrl.len_err    = w_len_err;
        w_s1_ctrl.shift_err  = w_shift_err;
        w_s1_ctrl.sb.slot    = i_slot_idx;
        w_s1_ctrl.sb.symb    = i_symb_idx;
        w_s1_ctrl.sb.prb     = i_prb_idx;
        w_s1_ctrl.sb.ch_type = i_ch_type;
        w_s1_ctrl.sb.info    = i_info;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_shift_q  <= '0;
            r_s1_ctrl  <= '0;
            r_s1_din   <= '0;
            r_s1_shift <= '0;
            r_s2_ctrl  <= '0;
            r_s3_ctrl  <= '0;
            r_dout     <= '0;
        end else begin
            r_cnt <= w_cnt_d;
            if (i_vld && i_sop) begin
                r_shift_q <= i_shift;
            end
            r_s1_ctrl  <= w_s1_ctrl;
            r_s1_din   <= i_din;
            r_s1_shift <= w_shift_use;
            r_s2_ctrl  <= r_s1_ctrl;
            r_s3_ctrl  <= r_s2_ctrl;
            r_dout     <= {w_y_i, w_y_q};
        end
    end

    bfp_expand_lane #(
        .Num (Num)
    ) u_lane_i (
        .clk     (clk),
        .rst     (rst),
        .i_vld   (r_s1_ctrl.vld),
        .i_mant  (r_s1_din[2*Num-1:Num]),
        .i_shift (r_s1_shift),
        .o_y     (w_y_i)
    );

    bfp_expand_lane #(
        .Num (Num)
    ) u_lane_q (
        .clk     (clk),
        .rst     (rst),
        .i_vld   (r_s1_ctrl.vld),
        .i_mant  (r_s1_din[Num-1:0]),
        .i_shift (r_s1_shift),
        .o_y     (w_y_q)
    );

    assign o_sel       = r_s3_ctrl.sel;
    assign o_sop       = r_s3_ctrl.sop;
    assign o_eop       = r_s3_ctrl.eop;
    assign o_vld       = r_s3_ctrl.vld;
    assign o_len_err   = r_s3_ctrl.len_err;
    assign o_shift_err = r_s3_ctrl.shift_err;
    assign o_slot_idx  = r_s3_ctrl.sb.slot;
    assign o_symb_idx  = r_s3_ctrl.sb.symb;
    assign o_prb_idx   = r_s3_ctrl.sb.prb;
    assign o_type      = r_s3_ctrl.sb.ch_type;
    assign o_info      = r_s3_ctrl.sb.info;
    assign o_dout      = r_dout;

endmodule

// File: tb/tb_decompress_bit.sv
// Self-checking bench for decompress_bit: directed scenarios plus randomized PRB
// traffic compared against a behavioural model of the decompressor.
module tb_decompress_bit;

    localparam int NUM     = 7;
    localparam int PRB_LEN = 12;

    typedef struct packed {
        logic        sel;
        logic        sop;
        logic        eop;
        logic        vld;
        logic        len_err;
        logic        shift_err;
        logic [31:0] side;
        logic [31:0] dout;
    } obs_t;

    typedef struct packed {
        logic           vld;
        logic [NUM-1:0] mi;
        logic [NUM-1:0] mq;
        logic [3:0]     s;
        logic [8:0]     prb;
    } rt_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_sel, i_sop, i_eop, i_vld;
    logic [2*NUM-1:0] i_din;
    logic [3:0]       i_shift;
    logic [6:0]       i_slot_idx;
    logic [3:0]       i_symb_idx;
    logic [8:0]       i_prb_idx;
    logic [3:0]       i_ch_type;
    logic [7:0]       i_info;
    logic             o_sel, o_sop, o_eop, o_vld;
    logic [31:0]      o_dout;
    logic [6:0]       o_slot_idx;
    logic [3:0]       o_symb_idx;
    logic [8:0]       o_prb_idx;
    logic [3:0]       o_type;
    logic [7:0]       o_info;
    logic             o_len_err, o_shift_err;

    int   checks = 0;
    int   errors = 0;
    obs_t obs, cur;
    obs_t pipe [3];
    rt_t  rpipe [3];
    rt_t  rcur;
    int   m_cnt = 0;
    int   m_shq = 0;

    always #5 clk = ~clk;

    decompress_bit #(
        .Num     (NUM),
        .PRB_LEN (PRB_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_sel       (i_sel),
        .i_sop       (i_sop),
        .i_eop       (i_eop),
        .i_vld       (i_vld),
        .i_din       (i_din),
        .i_shift     (i_shift),
        .i_slot_idx  (i_slot_idx),
        .i_symb_idx  (i_symb_idx),
        .i_prb_idx   (i_prb_idx),
        .i_ch_type   (i_ch_type),
        .i_info      (i_info),
        .o_sel       (o_sel),
        .o_sop       (o_sop),
        .o_eop       (o_eop),
        .o_vld       (o_vld),
        .o_dout      (o_dout),
        .o_slot_idx  (o_slot_idx),
        .o_symb_idx  (o_symb_idx),
        .o_prb_idx   (o_prb_idx),
        .o_type      (o_type),
        .o_info      (o_info),
        .o_len_err   (o_len_err),
        .o_shift_err (o_shift_err)
    );

    // Value of mantissa m scaled to 16 bits, divided by 2^s with floor rounding.
    function automatic logic [15:0] expand(input logic [NUM-1:0] m, input int s);
        int v, d, q;
        v = (int'(m) >= (1 << (NUM - 1))) ? int'(m) - (1 << NUM) : int'(m);
        v = v * (1 << (16 - NUM));
        d = 1 << s;
        q = v / d;
        if ((v % d != 0) && (v < 0)) q = q - 1;
        return q[15:0];
    endfunction

    // Drive one cycle, advance the model, and capture DUT outputs after the edge.
    task automatic cycle(input logic r, input logic vld, input logic sop, input logic eop,
                         input logic sel, input logic [2*NUM-1:0] din, input logic [3:0] sh,
                         input logic [31:0] sb);
        obs_t e;
        rt_t  t;
        int   s, cnt_new;
        @(negedge clk);
        rst     = r;
        i_vld   = vld;
        i_sop   = sop;
        i_eop   = eop;
        i_sel   = sel;
        i_din   = din;
        i_shift = sh;
        {i_slot_idx, i_symb_idx, i_prb_idx, i_ch_type, i_info} = sb;
        e      = '0;
        t      = '0;
        e.sel  = sel;
        e.sop  = sop;
        e.eop  = eop;
        e.vld  = vld;
        e.side = sb;
        if (vld) begin
            s = sop ? int'(sh) : m_shq;
            if (sop) begin
                if (m_cnt != 0) e.len_err = 1'b1;
                cnt_new = 1;
            end else begin
                if (m_cnt == 0) e.len_err = 1'b1;
                cnt_new = m_cnt + 1;
            end
            if (eop) begin
                if (cnt_new != PRB_LEN) e.len_err = 1'b1;
                cnt_new = 0;
            end
            if ((s > 9) || (!sop && (int'(sh) != m_shq))) e.shift_err = 1'b1;
            if (sop) m_shq = int'(sh);
            m_cnt  = cnt_new;
            e.dout = {expand(din[2*NUM-1:NUM], s), expand(din[NUM-1:0], s)};
            t.vld  = 1'b1;
            t.mi   = din[2*NUM-1:NUM];
            t.mq   = din[NUM-1:0];
            t.s    = 4'(s);
            t.prb  = sb[20:12];
        end
        if (r) begin
            for (int k = 0; k < 3; k++) begin
                pipe[k]  = '0;
                rpipe[k] = '0;
            end
            m_cnt = 0;
            m_shq = 0;
        end else begin
            pipe[2]  = pipe[1];
            pipe[1]  = pipe[0];
            pipe[0]  = e;
            rpipe[2] = rpipe[1];
            rpipe[1] = rpipe[0];
            rpipe[0] = t;
        end
        @(posedge clk);
        #1;
        obs = {o_sel, o_sop, o_eop, o_vld, o_len_err, o_shift_err,
               o_slot_idx, o_symb_idx, o_prb_idx, o_type, o_info, o_dout};
        cur  = pipe[2];
        rcur = rpipe[2];
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 14'h1234, 4'h3, 32'hDEAD_BEEF);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
    endtask

    task automatic test_basic();
        int nv = 0;
        int first = -1;
        for (int i = 0; i < 15; i++) begin
            if (i < 12) cycle(1'b0, 1'b1, i == 0, i == 11, 1'b1, {7'h3F, 7'h40}, 4'd0, 32'h0A0B_0C0D);
            else        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 4'd0, '0);
            checks++;
            if (obs !== cur) begin
                errors++;
                $display("FAIL basic_model i=%0d: got %h expected %h", i, obs, cur);
            end
            if (o_vld) begin
                if (first < 0) first = i;
                nv++;
                checks++;
                if ({o_dout, o_len_err, o_shift_err} !== {32'h7E00_8000, 2'b00}) begin
                    errors++;
                    $display("FAIL basic_dout i=%0d: got %h/%b%b expected 7e008000/00",
                             i, o_dout, o_len_err, o_shift_err);
                end
            end
        end
        checks++;
        if (nv != 12 || first != 2) begin
            errors++;
            $display("FAIL basic_latency: got %0d samples first at %0d expected 12 at 2", nv, first);
        end
    endtask

    task automatic test_shift();
        int nv = 0;
        int pulses = 0;
        int where = -1;
        for (int i = 0; i < 15; i++) begin
            if (i < 12) cycle(1'b0, 1'b1, i == 0, i == 11, 1'b0, {7'h3F, 7'h40},
                              (i == 5) ? 4'd5 : 4'd3, 32'h1111_2222);
            else        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 4'd3, '0);
            checks++;
            if (obs !== cur) begin
                errors++;
                $display("FAIL shift_model i=%0d: got %h expected %h", i, obs, cur);
            end
            if (o_vld) begin
                checks++;
                if (o_dout !== 32'h0FC0_F000) begin
                    errors++;
                    $display("FAIL shift_dout i=%0d: got %h expected 0fc0f000", i, o_dout);
                end
                if (o_shift_err) begin
                    pulses++;
                    where = nv;
                end
                nv++;
            end
        end
        checks++;
        if (pulses != 1 || where != 5) begin
            errors++;
            $display("FAIL shift_err_pulse: got %0d pulses at %0d expected 1 at 5", pulses, where);
        end
    endtask

    task automatic test_len();
        int pulses = 0;
        int late   = 0;
        logic at_eop = 1'b0;
        for (int i = 0; i < 26; i++) begin
            if (i < 11)      cycle(1'b0, 1'b1, i == 0, i == 10, 1'b0, 14'h0155, 4'd1, 32'h3);
            else if (i < 23) cycle(1'b0, 1'b1, i == 11, i == 22, 1'b0, 14'h2AAA, 4'd2, 32'h4);
            else             cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 4'd0, '0);
            checks++;
            if (obs !== cur) begin
                errors++;
                $display("FAIL len_model i=%0d: got %h expected %h", i, obs, cur);
            end
            if (o_len_err) begin
                if (i <= 12) begin
                    pulses++;
                    at_eop = o_eop;
                end else begin
                    late++;
                end
            end
        end
        checks++;
        if (pulses != 1 || !at_eop || late != 0) begin
            errors++;
            $display("FAIL len_err_pulse: got %0d/%b/%0d expected 1/1/0", pulses, at_eop, late);
        end
    endtask

    task automatic test_shift_big();
        logic seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i < 12) cycle(1'b0, 1'b1, i == 0, i == 11, 1'b1, {7'h01, 7'h40}, 4'd12, 32'h5);
            else        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 4'd0, '0);
            checks++;
            if (obs !== cur) begin
                errors++;
                $display("FAIL big_model i=%0d: got %h expected %h", i, obs, cur);
            end
            if (o_vld && !seen) begin
                seen = 1'b1;
                checks++;
                if ({o_shift_err, o_dout} !== {1'b1, 32'h0000_FFF8}) begin
                    errors++;
                    $display("FAIL big_shift: got %b/%h expected 1/0000fff8", o_shift_err, o_dout);
                end
            end
        end
    endtask

    task automatic test_random();
        int   len, k, sh, mant, yi;
        logic [31:0] sb;
        logic [2*NUM-1:0] din;
        logic [NUM-1:0] rm;
        for (int p = 0; p < 40; p++) begin
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 13)) : PRB_LEN;
            sh  = int'($urandom_range(0, 9));
            sb  = $urandom;
            k   = 0;
            while (k < len) begin
                if ($urandom_range(0, 3) == 0) begin
                    cycle(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 14'($urandom),
                          4'($urandom), sb);
                end else begin
                    din = 14'($urandom);
                    cycle(1'b0, 1'b1, k == 0, k == len - 1, 1'b1, din,
                          ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'(sh), sb);
                    k++;
                end
                checks++;
                if (obs !== cur) begin
                    errors++;
                    $display("FAIL rand_model p=%0d: got %h expected %h", p, obs, cur);
                end
                if (o_vld) begin
                    // Recompress: exact for exponents up to 9.
                    yi   = int'($signed(o_dout[31:16]));
                    mant = (yi * (1 << rcur.s)) / (1 << (16 - NUM));
                    rm   = mant[NUM-1:0];
                    checks++;
                    if (rm !== rcur.mi || o_prb_idx !== rcur.prb) begin
                        errors++;
                        $display("FAIL rand_roundtrip p=%0d: got %h prb %h expected %h prb %h",
                                 p, rm, o_prb_idx, rcur.mi, rcur.prb);
                    end
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 4'd0, '0);
            checks++;
            if (obs !== cur) begin
                errors++;
                $display("FAIL rand_flush i=%0d: got %h expected %h", i, obs, cur);
            end
        end
    endtask

    task automatic test_rst_mid();
        logic seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, i == 0, 1'b0, 1'b0, 14'($urandom), 4'd2, 32'h7);
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 14'h3FFF, 4'd2, 32'hFFFF_FFFF);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL rst_mid_zero: got %h expected 0", obs);
        end
        for (int i = 0; i < 6; i++) begin
            if (i < 3) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'($urandom), 4'd2, 32'h8);
            else       cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 4'd0, '0);
            checks++;
            if (obs !== cur) begin
                errors++;
                $display("FAIL rst_mid_model i=%0d: got %h expected %h", i, obs, cur);
            end
            if (o_vld && !seen) begin
                seen = 1'b1;
                checks++;
                if (o_len_err !== 1'b1) begin
                    errors++;
                    $display("FAIL rst_mid_orphan: got %b expected 1", o_len_err);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_mid_output: got no valid output expected 1");
        end
    endtask

    initial begin
        rst = 1'b1;
        {i_sel, i_sop, i_eop, i_vld} = '0;
        i_din   = '0;
        i_shift = '0;
        {i_slot_idx, i_symb_idx, i_prb_idx, i_ch_type, i_info} = '0;
        test_reset();
        test_basic();
        test_shift();
        test_len();
        test_shift_big();
        test_random();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
